enemy_slot_ctrl: RTL
====================

// Module: enemy_slot_ctrl
// PURPOSE
//   Owns the state of one on-screen enemy and produces the type/health/x_mid/y_mid
//   descriptor that the enemy sprite renderer consumes.
//   Handles spawn, per-frame movement, bullet hits, death flash and escape off the
//   bottom of the screen.
//   One instance per enemy slot. Instances sit between the game spawner/collision
//   logic and the per-pixel drawing path.
// PARAMETERS
//   Y_START     10'd40   y_mid loaded on spawn
//   Y_BOTTOM    10'd472  y_mid >= this on a frame update -> enemy escapes
//   X_MIN       10'd8    left clamp for zigzag motion
//   X_MAX       10'd631  right clamp for zigzag motion
//   SPD0        2        px/frame descent, type 0
//   SPD1        1        px/frame descent, type 1
//   SPD2        1        px/frame descent, type 2
//   DEATH_FRM   8        frames spent in DYING before returning to IDLE
//   HIT_CD      4        frames of hit immunity after a non-fatal hit
// PORTS
//   clk          in   1   system clock
//   rst_n        in   1   asynchronous active-low reset
//   frame_tick   in   1   1-cycle pulse, once per frame (start of vblank)
//   spawn_req    in   1   request to spawn into this slot (level, sampled each clk)
//   spawn_type   in   2   type for spawn: 0,1,2 valid; 3 invalid
//   spawn_x      in   10  x_mid for spawn
//   hit          in   1   1-cycle pulse: bullet overlapped this enemy
//   spawn_ack    out  1   1-cycle pulse: spawn accepted
//   active       out  1   1 in ACTIVE; the renderer is enabled only when 1
//   dying        out  1   1 in DYING (top level blinks the sprite)
//   type         out  2   enemy type to renderer
//   health       out  4   remaining health to renderer
//   x_mid        out  10  sprite centre x
//   y_mid        out  10  sprite centre y
//   killed       out  1   1-cycle pulse: health reached 0 (score event)
//   escaped      out  1   1-cycle pulse: enemy passed Y_BOTTOM (player damage)
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; all outputs 0; internal frame/cooldown
//   counters 0; zigzag direction = +x.
// - States:
//   IDLE   -> ACTIVE   on spawn_req=1 with spawn_type!=3.
//   ACTIVE -> DYING    on a fatal hit.
//   ACTIVE -> IDLE     on escape.
//   DYING  -> IDLE     after DEATH_FRM frame_ticks.
// - Spawn: in IDLE with spawn_req=1 and spawn_type!=3, on the next edge:
//   - spawn_ack=1 for that one cycle, and active=1;
//   - type=spawn_type, x_mid=spawn_x, y_mid=Y_START, cooldown=0;
//   - health loaded by type: type0=1, type1=4, type2=2.
//   spawn_type=3, or spawn_req in any non-IDLE state: ignored, no ack.
// - Movement (ACTIVE, on frame_tick):
//   - y_mid += SPDn for the current type.
//   - Type 2 only: x_mid moves +/-1 per frame; direction flips every 16 frames
//     (4-bit frame counter wrap) or on reaching X_MIN/X_MAX. x_mid never leaves
//     [X_MIN, X_MAX].
//   - Types 0 and 1 never change x_mid.
// - Escape: evaluated on the frame_tick update using the new y_mid.
//   - If new y_mid >= Y_BOTTOM: escaped=1 for one cycle and state -> IDLE.
//   - y_mid is saturated to Y_BOTTOM (no 10-bit wrap).
// - Hit (ACTIVE, hit=1, cooldown=0):
//   - health>1: health-=1 and cooldown=HIT_CD. Cooldown decrements on each
//     frame_tick down to 0. Hits while cooldown!=0 are ignored.
//   - health==1: health=0, killed=1 for one cycle, state -> DYING, frame count=0.
//   - hit is ignored in IDLE and DYING.
// - Hit and frame_tick in the same cycle: both are applied.
//   - If the hit is fatal, the kill takes priority: killed=1, escaped=0,
//     state=DYING, and no movement is applied.
//   - If the hit is non-fatal and the enemy escapes that frame: escaped=1 and the
//     decremented health is visible for that cycle.
// - DYING: active=0, dying=1; position, type and health are frozen.
//   - Counts frame_ticks; on the DEATH_FRM-th tick -> IDLE and dying=0.
// - IDLE: active=0, dying=0; type/health/x_mid/y_mid hold their last values.
// - killed and escaped are never 1 in the same cycle. spawn_ack never coincides
//   with either.
// - Arithmetic: all position math is unsigned 10-bit with an explicit 11-bit
//   compare before the clamp/saturate.
// TESTING
// 1. Reset/spawn:
//    - Assert rst_n=0 mid-ACTIVE -> all outputs 0 immediately (async).
//    - Release; spawn_req=1, type=1, x=320 -> spawn_ack pulse; active=1,
//      health=4, x_mid=320, y_mid=40.
// 2. Multi-hit with cooldown:
//    - Type 1, hit at frame 0 -> health 3.
//    - hit at frame 2 -> ignored.
//    - hit at frame 4 -> health 2.
//    - Two further spaced hits -> killed pulse, dying=1 for 8 frame_ticks,
//      then IDLE.
// 3. Escape:
//    - Type 0 spawned, y=40, SPD0=2 -> after 216 frame_ticks y_mid=472,
//      escaped pulse, active=0.
//    - No killed pulse.
// 4. Zigzag/clamp:
//    - Type 2, spawn_x=630 -> x_mid reaches 631, direction flips, next frame
//      630.
//    - 16-frame flip is verified from spawn_x=320 (x peaks at 336, returns).
// 5. Simultaneous events:
//    - Fatal hit on the same cycle as the escaping frame_tick -> killed=1,
//      escaped=0, state DYING.
//    - spawn_req during DYING -> no ack.
// 6. Invalid/ignored:
//    - spawn_type=3 -> no ack, stays IDLE.
//    - hit in IDLE -> no state or output change.

Source files
------------

// File: rtl/enemy_slot_ctrl.sv
// enemy_slot_ctrl: one on-screen enemy slot. Tracks spawn, per-frame descent,
// type-2 zigzag, bullet hits with immunity cooldown, death flash and escape,
// and presents the type/health/position descriptor to the sprite renderer.
// The renderer-facing type port is named enemy_type because "type" is a
// reserved word in SystemVerilog.
module enemy_slot_ctrl #(
  parameter logic [9:0] Y_START   = 10'd40,
  parameter logic [9:0] Y_BOTTOM  = 10'd472,
  parameter logic [9:0] X_MIN     = 10'd8,
  parameter logic [9:0] X_MAX     = 10'd631,
  parameter logic [9:0] SPD0      = 10'd2,
  parameter logic [9:0] SPD1      = 10'd1,
  parameter logic [9:0] SPD2      = 10'd1,
  parameter logic [3:0] DEATH_FRM = 4'd8,
  parameter logic [3:0] HIT_CD    = 4'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       spawn_req,
  input  logic [1:0] spawn_type,
  input  logic [9:0] spawn_x,
  input  logic       hit,
  output logic       spawn_ack,
  output logic       active,
  output logic       dying,
  output logic [1:0] enemy_type,
  output logic [3:0] health,
  output logic [9:0] x_mid,
  output logic [9:0] y_mid,
  output logic       killed,
  output logic       escaped
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DYING  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  type_q, type_d;
  logic [3:0]  health_q, health_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [3:0]  cd_q, cd_d;       // hit immunity, in frames
  logic [3:0]  frm_q, frm_d;     // zigzag period counter while ACTIVE, death frames while DYING
  logic        dir_q, dir_d;     // zigzag direction, 1 = +x
  logic        ack_q, ack_d;
  logic        killed_q, killed_d;
  logic        escaped_q, escaped_d;

  // Movement helpers, widened to 11 bits so the bound compares cannot wrap.
  logic [9:0]  spd;
  logic [10:0] y_sum;
  logic [10:0] x_inc;
  logic [9:0]  x_step;
  logic        x_at_edge;
  logic        hit_ok;
  logic        hit_fatal;

  // Per-type descent speed and the next zigzag x position with clamping.
  always_comb begin
    spd       = SPD2;
    x_step    = x_q;
    x_at_edge = 1'b0;
    x_inc     = {1'b0, x_q} + 11'd1;
    case (type_q)
      2'd0:    spd = SPD0;
      2'd1:    spd = SPD1;
      default: spd = SPD2;
    endcase
    y_sum = {1'b0, y_q} + {1'b0, spd};
    if (dir_q) begin
      if (x_inc >= {1'b0, X_MAX}) begin
        x_step    = X_MAX;
        x_at_edge = 1'b1;
      end else begin
        x_step = x_inc[9:0];
      end
    end else begin
      if ({1'b0, x_q} <= ({1'b0, X_MIN} + 11'd1)) begin
        x_step    = X_MIN;
        x_at_edge = 1'b1;
      end else begin
        x_step = x_q - 10'd1;
      end
    end
    hit_ok    = hit && (cd_q == 4'd0);
    hit_fatal = hit_ok && (health_q <= 4'd1);
  end

  // Next-state and register updates for spawn, movement, hits and death timing.
  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    health_d  = health_q;
    x_d       = x_q;
    y_d       = y_q;
    cd_d      = cd_q;
    frm_d     = frm_q;
    dir_d     = dir_q;
    ack_d     = 1'b0;
    killed_d  = 1'b0;
    escaped_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (spawn_req && (spawn_type != 2'd3)) begin
          state_d = S_ACTIVE;
          ack_d   = 1'b1;
          type_d  = spawn_type;
          x_d     = spawn_x;
          y_d     = Y_START;
          cd_d    = 4'd0;
          frm_d   = 4'd0;
          dir_d   = 1'b1;
          case (spawn_type)
            2'd0:    health_d = 4'd1;
            2'd1:    health_d = 4'd4;
            default: health_d = 4'd2;
          endcase
        end
      end
      S_ACTIVE: begin
        if (hit_fatal) begin
          // A kill freezes the enemy where it is, even on a frame update.
          health_d = 4'd0;
          killed_d = 1'b1;
          state_d  = S_DYING;
          frm_d    = 4'd0;
        end else begin
          if (hit_ok) begin
            health_d = health_q - 4'd1;
            cd_d     = HIT_CD;
          end else if (frame_tick && (cd_q != 4'd0)) begin
            cd_d = cd_q - 4'd1;
          end
          if (frame_tick) begin
            if (y_sum >= {1'b0, Y_BOTTOM}) begin
              y_d       = Y_BOTTOM;
              escaped_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              y_d = y_sum[9:0];
            end
            if (type_q == 2'd2) begin
              x_d   = x_step;
              frm_d = frm_q + 4'd1;
              if (x_at_edge || (frm_q == 4'hF)) begin
                dir_d = ~dir_q;
              end
            end
          end
        end
      end
      S_DYING: begin
        if (frame_tick) begin
          if (frm_q == (DEATH_FRM - 4'd1)) begin
            state_d = S_IDLE;
            frm_d   = 4'd0;
          end else begin
            frm_d = frm_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      type_q    <= 2'd0;
      health_q  <= 4'd0;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      cd_q      <= 4'd0;
      frm_q     <= 4'd0;
      dir_q     <= 1'b1;
      ack_q     <= 1'b0;
      killed_q  <= 1'b0;
      escaped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      health_q  <= health_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cd_q      <= cd_d;
      frm_q     <= frm_d;
      dir_q     <= dir_d;
      ack_q     <= ack_d;
      killed_q  <= killed_d;
      escaped_q <= escaped_d;
    end
  end

  assign spawn_ack  = ack_q;
  assign active     = (state_q == S_ACTIVE);
  assign dying      = (state_q == S_DYING);
  assign enemy_type = type_q;
  assign health     = health_q;
  assign x_mid      = x_q;
  assign y_mid      = y_q;
  assign killed     = killed_q;
  assign escaped    = escaped_q;

endmodule
